// File: rtl/cache_wb_pkg.sv
// Shared FSM state type and derived-width helpers for the write-back cache.
package cache_wb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        RESPOND
    } state_t;

    function automatic int unsigned idx_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned aw, input int unsigned sets);
        return aw - $clog2(sets);
    endfunction

    function automatic int unsigned way_w(input int unsigned ways);
        return $clog2(ways);
    endfunction

endpackage

// File: rtl/cache_wb_lru.sv
// True-LRU age tracking per set: age 0 is youngest, WAYS-1 is the LRU way.
module cache_wb_lru
    import cache_wb_pkg::*;
#(
    parameter int unsigned SETS = 4,
    parameter int unsigned WAYS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [idx_w(SETS)-1:0]        idx_i,
    input  logic [way_w(WAYS)-1:0]        way_i,
    input  logic                          upd_i,
    output logic [way_w(WAYS)-1:0]        lru_way_o
);

    localparam int unsigned WW = way_w(WAYS);

    logic [WW-1:0] age_q [SETS][WAYS];

    // Reset order makes way0 the oldest in every set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WW'(WAYS - 1 - w);
                end
            end
        end else if (upd_i) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WW'(w) == way_i) begin
                    age_q[idx_i][w] <= '0;
                end else if (age_q[idx_i][w] < age_q[idx_i][way_i]) begin
                    age_q[idx_i][w] <= age_q[idx_i][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lru_way_o = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[idx_i][w] == WW'(WAYS - 1)) begin
                lru_way_o = WW'(w);
            end
        end
    end

endmodule

// File: rtl/cache_wb_top.sv
// Set-associative write-back, write-allocate cache with LRU replacement.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
module cache_wb_top
    import cache_wb_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned WAYS       = 4,
    parameter int unsigned TOTAL_SIZE = 16,
    parameter int unsigned RAM_DEPTH  = 256
`ifdef CACHE_STATS_EN
    ,
    parameter int unsigned STAT_W     = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          re,
    input  logic                          we,
    input  logic [$clog2(RAM_DEPTH)-1:0]  addr,
    input  logic [WIDTH-1:0]              data_in,
    output logic                          ready,
    output logic                          done,
    output logic [WIDTH-1:0]              data_out,
    output logic [$clog2(RAM_DEPTH)-1:0]  RAM_addr,
    output logic [WIDTH-1:0]              RAM_data_out,
    output logic                          RAM_we,
    output logic                          RAM_re,
    input  logic [WIDTH-1:0]              RAM_data_in,
    input  logic                          RAM_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]             hit_count,
    output logic [STAT_W-1:0]             miss_count,
    output logic [STAT_W-1:0]             wb_count
`endif
);

    localparam int unsigned SETS = TOTAL_SIZE / WAYS;
    localparam int unsigned AW   = $clog2(RAM_DEPTH);
    localparam int unsigned IW   = idx_w(SETS);
    localparam int unsigned TW   = tag_w(AW, SETS);
    localparam int unsigned WW   = way_w(WAYS);

    state_t state_q, state_d;

    logic [AW-1:0]    req_addr_q;
    logic [WIDTH-1:0] req_data_q;
    logic             req_we_q;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [TW-1:0]    tag_q   [SETS][WAYS];
    logic [WIDTH-1:0] data_q  [SETS][WAYS];

    logic [WW-1:0]    victim_q, victim_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             done_q;

    logic [IW-1:0]    idx;
    logic [TW-1:0]    rtag;
    logic             hit, inv_found;
    logic [WW-1:0]    hit_way, inv_way, lru_way;

    logic             lru_upd;
    logic [WW-1:0]    acc_way;
    logic             line_wr;
    logic [WW-1:0]    line_way;
    logic [WIDTH-1:0] line_dat;
    logic             line_dirty;
    logic             clr_dirty;

    assign idx  = req_addr_q[IW-1:0];
    assign rtag = req_addr_q[AW-1:IW];

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[idx][w] && (tag_q[idx][w] == rtag)) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!inv_found && !valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    cache_wb_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .idx_i     (idx),
        .way_i     (acc_way),
        .upd_i     (lru_upd),
        .lru_way_o (lru_way)
    );

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        data_out_d = data_out_q;
        lru_upd    = 1'b0;
        acc_way    = victim_q;
        line_wr    = 1'b0;
        line_way   = victim_q;
        line_dat   = req_data_q;
        line_dirty = 1'b1;
        clr_dirty  = 1'b0;
        case (state_q)
            IDLE: begin
                if (re || we) state_d = LOOKUP;
            end
            LOOKUP: begin
                victim_d = inv_found ? inv_way : lru_way;
                if (hit) begin
                    lru_upd = 1'b1;
                    acc_way = hit_way;
                    if (req_we_q) begin
                        line_wr  = 1'b1;
                        line_way = hit_way;
                    end else begin
                        data_out_d = data_q[idx][hit_way];
                    end
                    state_d = RESPOND;
                end else if (valid_q[idx][victim_d] && dirty_q[idx][victim_d]) begin
                    state_d = WRITEBACK;
                end else if (!req_we_q) begin
                    state_d = FILL;
                end else begin
                    line_wr  = 1'b1;
                    line_way = victim_d;
                    lru_upd  = 1'b1;
                    acc_way  = victim_d;
                    state_d  = RESPOND;
                end
            end
            WRITEBACK: begin
                if (RAM_ack) begin
                    clr_dirty = 1'b1;
                    if (req_we_q) begin
                        line_wr = 1'b1;
                        lru_upd = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (RAM_ack) begin
                    line_wr    = 1'b1;
                    line_dat   = RAM_data_in;
                    line_dirty = 1'b0;
                    lru_upd    = 1'b1;
                    data_out_d = RAM_data_in;
                    state_d    = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            data_out_q <= data_out_d;
            done_q     <= (state_q == RESPOND);
            if (state_q == IDLE && (re || we)) begin
                req_addr_q <= addr;
                req_data_q <= data_in;
                req_we_q   <= we;
            end
        end
    end

    // A write allocate in the same cycle as a write-back ack must leave the line dirty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (clr_dirty) dirty_q[idx][victim_q] <= 1'b0;
            if (line_wr) begin
                valid_q[idx][line_way] <= 1'b1;
                dirty_q[idx][line_way] <= line_dirty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_wr) begin
            data_q[idx][line_way] <= line_dat;
            tag_q[idx][line_way]  <= rtag;
        end
    end

    assign ready        = (state_q == IDLE);
    assign done         = done_q;
    assign data_out     = data_out_q;
    assign RAM_we       = (state_q == WRITEBACK);
    assign RAM_re       = (state_q == FILL);
    assign RAM_data_out = (state_q == WRITEBACK) ? data_q[idx][victim_q] : '0;

    always_comb begin
        RAM_addr = '0;
        if (state_q == WRITEBACK) RAM_addr = {tag_q[idx][victim_q], idx};
        else if (state_q == FILL) RAM_addr = req_addr_q;
    end

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_q, miss_q, wb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            if (state_q == LOOKUP) begin
                if (hit) begin
                    if (hit_q != '1) hit_q <= hit_q + 1'b1;
                end else if (miss_q != '1) begin
                    miss_q <= miss_q + 1'b1;
                end
            end
            if (state_q == WRITEBACK && RAM_ack && wb_q != '1) wb_q <= wb_q + 1'b1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`endif

endmodule
